// File: rtl/rv_pkg.sv
// Shared register-file constants and clear-sequencer state encoding.
package rv_pkg;

  localparam int unsigned RV_XLEN = 64;
  localparam int unsigned RV_NREG = 32;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rv_rf_rdsel.sv
// Per-read-port word select: x0 reads zero, then the highest-indexed matching
// same-cycle write is forwarded, otherwise the stored array word is returned.
module rv_rf_rdsel #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned AW   = 5,
  parameter int unsigned NWR  = 1
) (
  input  logic [AW-1:0]       rd_addr_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [XLEN-1:0]     arr_data_i,
  output logic [XLEN-1:0]     sel_data_o
);

  always_comb begin
    sel_data_o = arr_data_i;
    // Ascending scan: the last match, i.e. the highest port, takes effect.
    for (int unsigned w = 0; w < NWR; w++) begin
      if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i)) begin
        sel_data_o = wr_data_i[w*XLEN +: XLEN];
      end
    end
    if (rd_addr_i == '0) begin
      sel_data_o = '0;
    end
  end

endmodule

// File: rtl/rv_rf_mp.sv
// Multi-port integer register file with x0 hardwired to zero, write-first
// forwarding, highest-port-wins write priority and a post-reset clear sequencer.
module rv_rf_mp
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = RV_XLEN,
  parameter int unsigned NREG = RV_NREG,
  parameter int unsigned AW   = $clog2(NREG),
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic                init_busy_o
);

  rf_state_e                r_state;
  rf_state_e                w_state_nxt;
  logic [AW-1:0]            r_cnt;
  logic [AW-1:0]            w_cnt_nxt;
  logic [XLEN-1:0]          r_mem [NREG];
  logic [NRD-1:0][XLEN-1:0] r_rd;
  logic [NRD-1:0][XLEN-1:0] w_arr;
  logic [NRD-1:0][XLEN-1:0] w_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RF_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW'(NREG - 1)) begin
          w_state_nxt = RF_RUN;
        end
      end
      RF_RUN:  w_state_nxt = RF_RUN;
      default: w_state_nxt = RF_INIT;
    endcase
  end

  // No reset on the array itself; the sequencer zeroes one entry per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == RF_INIT) begin
        r_mem[r_cnt] <= '0;
      end else begin
        for (int unsigned w = 0; w < NWR; w++) begin
          if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
            r_mem[wr_addr_i[w*AW +: AW]] <= wr_data_i[w*XLEN +: XLEN];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign w_arr[p] = r_mem[rd_addr_i[p*AW +: AW]];

    rv_rf_rdsel #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_rdsel (
      .rd_addr_i  (rd_addr_i[p*AW +: AW]),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .arr_data_i (w_arr[p]),
      .sel_data_o (w_sel[p])
    );

    assign rd_data_o[p*XLEN +: XLEN] = r_rd[p];
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NRD; p++) begin
      if (rst) begin
        r_rd[p] <= '0;
      end else if (rd_en_i[p]) begin
        r_rd[p] <= (r_state == RF_RUN) ? w_sel[p] : '0;
      end
    end
  end

  assign init_busy_o = (r_state == RF_INIT);

endmodule
